imm_gen_stage: RTL and testbench

- Parametrised, pipelined immediate-generation stage between decode and execute.
- Extends all RV32/RV64 immediate formats to XLEN and also pre-computes the PC-relative target, pc + imm.
- Adds CSR-uimm and shift-amount formats and a deterministic illegal-select flag (no X output).
- Registered output behind a valid/ready skid buffer with flush.

---
 rtl/riscv_imm_pkg.sv | 30 +++
 rtl/imm_decode.sv | 58 +++++
 rtl/imm_gen_stage.sv | 112 +++++++++++
 tb/tb_imm_gen_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_imm_pkg : format selects and pipeline entry type for imm_gen_stage
// Revision: 1.0
// ----------------------------------------------------------------------------
package riscv_imm_pkg;

  localparam int IMMSRC_W = 3;
  localparam int XLEN_MAX = 64;

  typedef enum logic [IMMSRC_W-1:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_Z     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_ILL   = 3'b111
  } imm_sel_t;

  // Sized for the widest datapath; narrower instances leave the top bits zero.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } imm_entry_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_decode : combinational RV32/RV64 immediate extraction and extension
// Revision: 1.0
// ----------------------------------------------------------------------------
module imm_decode
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  imm_sel_t        immsrc,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // instr holds bits [31:7]; OFS maps architectural bit numbers onto it.
  localparam int OFS = 7;

  logic [31:0] w_raw;
  logic        w_zext;
  logic        w_sign;

  assign w_sign = instr[31-OFS];

  always_comb begin
    w_raw   = '0;
    w_zext  = 1'b0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I: w_raw = {{20{w_sign}}, instr[31-OFS:20-OFS]};
      IMM_S: w_raw = {{20{w_sign}}, instr[31-OFS:25-OFS], instr[11-OFS:7-OFS]};
      IMM_B: w_raw = {{19{w_sign}}, instr[31-OFS], instr[7-OFS],
                      instr[30-OFS:25-OFS], instr[11-OFS:8-OFS], 1'b0};
      IMM_J: w_raw = {{11{w_sign}}, instr[31-OFS], instr[19-OFS:12-OFS],
                      instr[20-OFS], instr[30-OFS:21-OFS], 1'b0};
      IMM_U: w_raw = {instr[31-OFS:12-OFS], 12'b0};
      IMM_Z: begin
        w_raw  = {27'b0, instr[19-OFS:15-OFS]};
        w_zext = 1'b1;
      end
      IMM_SHAMT: begin
        // RV64 shift amounts carry a sixth bit in instr[25].
        w_raw  = {26'b0, (XLEN == 64) ? instr[25-OFS] : 1'b0, instr[24-OFS:20-OFS]};
        w_zext = 1'b1;
      end
      default: begin
        w_zext  = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

  // Signed formats are already sign-extended to 32 bits; widen per format.
  assign imm = w_zext ? XLEN'(w_raw) : XLEN'($signed(w_raw));

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_gen_stage : immediate + pc-relative target, registered behind a skid buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
module imm_gen_stage
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     in_instr,
  input  imm_sel_t        in_immsrc,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic [PC_W-1:0] w_target;
  imm_entry_t      w_new;
  logic            w_accept;
  logic            w_main_free;

  imm_entry_t      r_main;
  imm_entry_t      r_skid;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic            r_in_ready;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .immsrc  (in_immsrc),
    .imm     (w_imm),
    .illegal (w_illegal)
  );

  assign w_target = in_pc + w_imm[PC_W-1:0];

  always_comb begin
    w_new                   = '0;
    w_new.imm[XLEN-1:0]     = w_imm;
    w_new.target[PC_W-1:0]  = w_target;
    w_new.illegal           = w_illegal;
  end

  assign w_accept    = in_valid & r_in_ready;
  assign w_main_free = ~r_main_valid | out_ready;

  // in_ready is registered as the complement of the next skid state, so it
  // never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_main_free) begin
      r_main_valid <= r_skid_valid | w_accept;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_main_free) begin
      if (r_skid_valid) begin
        r_main <= r_skid;
      end else if (w_accept) begin
        r_main <= w_new;
      end
    end
    if (!w_main_free && w_accept) begin
      r_skid <= w_new;
    end
  end

  // Data flops are unreset; outputs are gated so they read zero when empty.
  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_valid;
  assign out_imm     = r_main_valid ? r_main.imm[XLEN-1:0]    : '0;
  assign out_target  = r_main_valid ? r_main.target[PC_W-1:0] : '0;
  assign out_illegal = r_main_valid & r_main.illegal;

  generate
    if (XLEN < XLEN_MAX) begin : g_imm_pad
      logic w_unused_imm_hi;
      assign w_unused_imm_hi = ^r_main.imm[XLEN_MAX-1:XLEN];
    end
    if (PC_W < XLEN_MAX) begin : g_target_pad
      logic w_unused_target_hi;
      assign w_unused_target_hi = ^r_main.target[XLEN_MAX-1:PC_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imm_gen_stage : scoreboard bench driving XLEN=32 and XLEN=64 stages in lockstep
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_imm_gen_stage;
  import riscv_imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] in_instr = '0;
  imm_sel_t    in_immsrc = IMM_I;
  logic [31:0] pc32 = '0;
  logic [63:0] pc64 = '0;

  logic        rdy32, rdy64, v32, v64, ill32, ill64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;

  typedef struct {
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd     = 1'b0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_pc(pc32), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .out_target(tgt32), .out_illegal(ill32)
  );

  imm_gen_stage #(.XLEN(64), .PC_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_pc(pc64), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64), .out_illegal(ill64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] sel,
                                            input int xlen);
    logic [63:0] r;
    case (sel)
      3'd0: r = {{52{ins[31]}}, ins[31:20]};
      3'd1: r = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: r = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: r = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: r = {{32{ins[31]}}, ins[31:12], 12'h000};
      3'd5: r = {59'd0, ins[19:15]};
      3'd6: r = (xlen == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
      default: r = 64'd0;
    endcase
    if (xlen == 32) r[63:32] = 32'd0;
    return r;
  endfunction

  // use_k selects hand-derived constants instead of the reference model
  task automatic push_exp(input logic [31:0] ins, input logic [2:0] sel, input logic [63:0] pc,
                          input bit use_k, input logic [31:0] k32, input logic [63:0] k64);
    exp_t e;
    logic [63:0] m32;
    m32     = model_imm(ins, sel, 32);
    e.imm32 = use_k ? k32 : m32[31:0];
    e.imm64 = use_k ? k64 : model_imm(ins, sel, 64);
    e.tgt32 = pc[31:0] + e.imm32;
    e.tgt64 = pc + e.imm64;
    e.ill   = (sel == 3'd7);
    q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] sel, input logic [63:0] pc);
    in_instr  = ins[31:7];
    in_immsrc = imm_sel_t'(sel);
    pc32      = pc[31:0];
    pc64      = pc;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [63:0] pc,
                      input bit use_k, input logic [31:0] k32, input logic [63:0] k64);
    int waited = 0;
    drive(ins, sel, pc);
    in_valid = 1'b1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    while (!rdy32 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("send_accept", rdy32, 1);
    if (rdy32) push_exp(ins, sel, pc, use_k, k32, k64);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && v32 && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", v32, 0);
      end else begin
        mon_e = q.pop_front();
        chk("imm32", imm32, mon_e.imm32);
        chk("tgt32", tgt32, mon_e.tgt32);
        chk("ill32", ill32, mon_e.ill);
        chk("valid64", v64, 1);
        chk("imm64", imm64, mon_e.imm64);
        chk("tgt64", tgt64, mon_e.tgt64);
        chk("ill64", ill64, mon_e.ill);
      end
    end
  end

  initial begin
    // Reset state before any clock edge
    #2;
    chk("rst_valid", v32, 0);
    chk("rst_ready", rdy32, 0);
    chk("rst_imm", imm32, 0);
    chk("rst_target", tgt32, 0);
    chk("rst_illegal", ill32, 0);
    chk("rst_valid64", v64, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_held", rdy32, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", rdy32, 1);
    chk("valid_after_rst", v32, 0);

    // Directed formats with hand-derived expectations
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 64'h100, 1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    chk("latency_valid", v32, 1);
    send(32'hFE000EE3, 3'd2, 64'h100, 1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC);
    send(32'h800000B7, 3'd4, 64'h100, 1, 32'h80000000, 64'hFFFFFFFF_80000000);
    send(32'h000F8073, 3'd5, 64'h40,  1, 32'h0000001F, 64'h1F);
    send(32'h800F8073, 3'd5, 64'h40,  1, 32'h0000001F, 64'h1F);
    send(32'hFFFFFFFF, 3'd7, 64'h200, 1, 32'h00000000, 64'h0);
    send(32'h03F00013, 3'd6, 64'h0,   1, 32'h0000001F, 64'h3F);
    send(32'h800000EF, 3'd3, 64'h1000, 1, 32'hFFF00000, 64'hFFFFFFFF_FFF00000);
    send(32'h80000023, 3'd1, 64'h800, 1, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800);
    send(32'h00000FA3, 3'd1, 64'h800, 1, 32'h0000001F, 64'h1F);
    wait_drain();

    // Backpressure: two entries fill main and skid, a third is refused
    out_ready = 1'b0;
    send(32'h12300093, 3'd0, 64'h300, 1, 32'h00000123, 64'h123);
    send(32'h45600093, 3'd0, 64'h300, 1, 32'h00000456, 64'h456);
    chk("bp_ready_low", rdy32, 0);
    drive(32'h78900093, 3'd0, 64'h300);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_held", rdy32, 0);
      chk("bp_valid", v32, 1);
      chk("bp_imm_stable", imm32, 32'h123);
      chk("bp_tgt_stable", tgt32, 32'h423);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_ready_back", rdy32, 1);
    chk("bp_empty", v32, 0);
    chk("bp_queue", q.size(), 0);

    // Flush with main and skid full plus a pending input
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 64'h10, 0, '0, '0);
    send(32'h00200093, 3'd0, 64'h10, 0, '0, '0);
    drive(32'h00300093, 3'd0, 64'h10);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_valid", v32, 0);
    chk("flush_ready", rdy32, 1);
    chk("flush_imm", imm32, 0);
    chk("flush_valid64", v64, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_stays_empty", v32, 0);
    end

    // Flush beats a simultaneous accept and drain
    out_ready = 1'b0;
    send(32'h00400093, 3'd0, 64'h20, 0, '0, '0);
    drive(32'h00500093, 3'd0, 64'h20);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_prio_valid", v32, 0);
    chk("flush_prio_ready", rdy32, 1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("flush_prio_empty", v32, 0);
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h00600093, 3'd0, 64'h30, 0, '0, '0);
    send(32'h00700093, 3'd0, 64'h30, 0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", v32, 0);
    chk("arst_ready", rdy32, 0);
    chk("arst_imm", imm32, 0);
    chk("arst_target", tgt32, 0);
    chk("arst_valid64", v64, 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_back", rdy32, 1);
    chk("arst_no_spurious", v32, 0);

    // Recovery plus randomized traffic with random backpressure
    send(32'h7FF00093, 3'd0, 64'h500, 1, 32'h000007FF, 64'h7FF);
    rnd = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 0, '0, '0);
    end
    rnd = 1'b0;
    wait_drain();
    @(posedge clk); #1;
    chk("final_idle", v32, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
